alu_cmd_ctrl: RTL and testbench

ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

---
 rtl/alu_cmd_ctrl_if.sv | 46 ++++
 rtl/alu_cmd_ctrl.sv | 173 +++++++++++++++++
 tb/tb_alu_cmd_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_ctrl_if.sv
// alu_cmd_ctrl_if -- signal bundle between the UART-to-ALU command controller and its
// surroundings (UART rx/tx byte streams, ALU command/result, status flags).
//
// Parameter:
//   DATA_WIDTH  width of UART bytes and ALU operands; the ALU result is 2*DATA_WIDTH.
//
// Signals:
//   rx_tdata/rx_tvalid/rx_tready  byte stream from the UART receiver
//   tx_tdata/tx_tvalid/tx_tready  byte stream to the UART transmitter
//   alu_op/alu_a/alu_b            latched command towards the ALU
//   alu_start                     one-cycle ALU start pulse
//   alu_done/alu_result           ALU completion pulse and result
//   busy                          controller is not idle
//   timeout                       one-cycle pulse when a partial frame is dropped
//
// Modports:
//   master  the controller side
//   slave   the environment side (UART, ALU, observer)
interface alu_cmd_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]   rx_tdata;
  logic                    rx_tvalid;
  logic                    rx_tready;
  logic [DATA_WIDTH-1:0]   tx_tdata;
  logic                    tx_tvalid;
  logic                    tx_tready;
  logic [DATA_WIDTH-1:0]   alu_op;
  logic [DATA_WIDTH-1:0]   alu_a;
  logic [DATA_WIDTH-1:0]   alu_b;
  logic                    alu_start;
  logic                    alu_done;
  logic [2*DATA_WIDTH-1:0] alu_result;
  logic                    busy;
  logic                    timeout;

  modport master (
    input  rx_tdata, rx_tvalid, tx_tready, alu_done, alu_result,
    output rx_tready, tx_tdata, tx_tvalid, alu_op, alu_a, alu_b, alu_start, busy, timeout
  );

  modport slave (
    output rx_tdata, rx_tvalid, tx_tready, alu_done, alu_result,
    input  rx_tready, tx_tdata, tx_tvalid, alu_op, alu_a, alu_b, alu_start, busy, timeout
  );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl -- receives 3-byte command frames (opcode, A, B) from a UART byte stream,
// launches the ALU for valid opcodes, and returns 3-byte response frames
// (status, result high byte, result low byte). Invalid opcodes still consume A and B and
// answer with status 0x01 and a zero result. A partial frame that stalls for
// TIMEOUT_CYCLES cycles is dropped without a response.
//
// Parameters:
//   DATA_WIDTH      byte / operand width
//   NUM_OPS         opcodes 0..NUM_OPS-1 are valid
//   TIMEOUT_CYCLES  maximum idle gap between bytes of one command frame
//
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   bus     controller side of alu_cmd_ctrl_if (rx/tx streams, ALU command, status)
module alu_cmd_ctrl #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned NUM_OPS        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  alu_cmd_ctrl_if.master bus
);

  localparam int unsigned GapW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GapW-1:0] GapMax = GapW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StGetA,
    StGetB,
    StExec,
    StWaitAlu,
    StSendStat,
    StSendHi,
    StSendLo
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   op_q, op_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d;
  logic [DATA_WIDTH-1:0]   b_q, b_d;
  logic [DATA_WIDTH-1:0]   status_q, status_d;
  logic [2*DATA_WIDTH-1:0] result_q, result_d;
  logic [GapW-1:0]         gap_q, gap_d;

  logic rx_ready;
  logic rx_acc;
  logic tx_valid;
  logic tx_acc;
  logic op_valid;
  logic receiving;
  logic timeout_hit;

  assign rx_ready  = (state_q == StIdle) || (state_q == StGetA) || (state_q == StGetB);
  assign rx_acc    = rx_ready && bus.rx_tvalid;
  assign tx_valid  = (state_q == StSendStat) || (state_q == StSendHi) || (state_q == StSendLo);
  assign tx_acc    = tx_valid && bus.tx_tready;
  assign op_valid  = (32'(op_q) < NUM_OPS);
  // The gap only runs while a frame is partially received; IDLE waits forever.
  assign receiving = (state_q == StGetA) || (state_q == StGetB);
  // A byte arriving on the last allowed cycle beats the timeout.
  assign timeout_hit = receiving && !rx_acc && (gap_q == GapMax);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      status_q <= '0;
      result_q <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      status_q <= status_d;
      result_q <= result_d;
      gap_q    <= gap_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    status_d = status_q;
    result_d = result_q;
    gap_d    = '0;

    unique case (state_q)
      StIdle: begin
        if (rx_acc) begin
          op_d    = bus.rx_tdata;
          state_d = StGetA;
        end
      end
      StGetA: begin
        if (rx_acc) begin
          a_d     = bus.rx_tdata;
          state_d = StGetB;
        end else if (timeout_hit) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StGetB: begin
        if (rx_acc) begin
          b_d = bus.rx_tdata;
          if (op_valid) begin
            state_d = StExec;
          end else begin
            // Keep framing: answer an unknown opcode without touching the ALU.
            status_d = DATA_WIDTH'(1);
            result_d = '0;
            state_d  = StSendStat;
          end
        end else if (timeout_hit) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StExec: begin
        state_d = StWaitAlu;
      end
      StWaitAlu: begin
        if (bus.alu_done) begin
          result_d = bus.alu_result;
          status_d = '0;
          state_d  = StSendStat;
        end
      end
      StSendStat: begin
        if (tx_acc) state_d = StSendHi;
      end
      StSendHi: begin
        if (tx_acc) state_d = StSendLo;
      end
      StSendLo: begin
        if (tx_acc) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    bus.tx_tdata = '0;
    unique case (state_q)
      StSendStat: bus.tx_tdata = status_q;
      StSendHi:   bus.tx_tdata = result_q[2*DATA_WIDTH-1:DATA_WIDTH];
      StSendLo:   bus.tx_tdata = result_q[DATA_WIDTH-1:0];
      default:    bus.tx_tdata = '0;
    endcase
  end

  assign bus.rx_tready = rx_ready;
  assign bus.tx_tvalid = tx_valid;
  assign bus.alu_op    = op_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_start = (state_q == StExec);
  assign bus.busy      = (state_q != StIdle);
  assign bus.timeout   = timeout_hit;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb_alu_cmd_ctrl -- directed bench for alu_cmd_ctrl with a frame-level reference model
// (received-byte count, pending ALU call, queue of response bytes, quiet-cycle count)
// checked every cycle, plus literal expectations per scenario.
module tb_alu_cmd_ctrl;
  localparam int unsigned DW   = 8;
  localparam int          NOPS = 8;
  localparam int          TO   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  alu_cmd_ctrl #(
    .DATA_WIDTH    (DW),
    .NUM_OPS       (NOPS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Observation log for literal expectations.
  logic [7:0] tx_log[$];
  int starts = 0;
  int start_cyc = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.tx_tvalid && bus.tx_tready) tx_log.push_back(bus.tx_tdata);
      if (bus.alu_start) begin
        starts++;
        start_cyc = cyc;
      end
    end
  end

  // Reference model, frame level.
  int         nrx = 0;
  int         quiet = 0;
  bit         exec_now = 1'b0;
  bit         wait_alu = 1'b0;
  logic [7:0] rq[$];
  logic [7:0] m_op = '0, m_a = '0, m_b = '0;
  bit         e_ready, e_tvalid, e_to, e_busy, acc;
  logic [7:0] e_tdata;

  always @(negedge clk) begin
    if (!rst_n) begin
      nrx = 0; quiet = 0; exec_now = 1'b0; wait_alu = 1'b0;
      rq.delete();
      m_op = '0; m_a = '0; m_b = '0;
    end
    e_ready  = !exec_now && !wait_alu && (rq.size() == 0);
    e_tvalid = (rq.size() != 0);
    e_tdata  = e_tvalid ? rq[0] : 8'h00;
    acc      = rst_n && e_ready && bus.rx_tvalid;
    e_to     = rst_n && e_ready && (nrx != 0) && !acc && (quiet + 1 == TO);
    e_busy   = !(e_ready && nrx == 0);

    chk("rx_tready", 32'(bus.rx_tready), 32'(e_ready));
    chk("tx_tvalid", 32'(bus.tx_tvalid), 32'(e_tvalid));
    if (e_tvalid || !rst_n) chk("tx_tdata", 32'(bus.tx_tdata), 32'(e_tdata));
    chk("alu_start", 32'(bus.alu_start), 32'(exec_now));
    chk("busy", 32'(bus.busy), 32'(e_busy));
    chk("timeout", 32'(bus.timeout), 32'(e_to));
    chk("alu_op", 32'(bus.alu_op), 32'(m_op));
    chk("alu_a", 32'(bus.alu_a), 32'(m_a));
    chk("alu_b", 32'(bus.alu_b), 32'(m_b));

    if (rst_n) begin
      if (exec_now) begin
        exec_now = 1'b0;
        wait_alu = 1'b1;
      end else if (wait_alu && bus.alu_done) begin
        wait_alu = 1'b0;
        rq.push_back(8'h00);
        rq.push_back(bus.alu_result[15:8]);
        rq.push_back(bus.alu_result[7:0]);
      end
      if (e_tvalid && bus.tx_tready) void'(rq.pop_front());
      if (acc) begin
        case (nrx)
          0:       m_op = bus.rx_tdata;
          1:       m_a  = bus.rx_tdata;
          default: m_b  = bus.rx_tdata;
        endcase
        quiet = 0;
        if (nrx == 2) begin
          nrx = 0;
          if (int'(m_op) < NOPS) exec_now = 1'b1;
          else begin
            rq.push_back(8'h01);
            rq.push_back(8'h00);
            rq.push_back(8'h00);
          end
        end else begin
          nrx++;
        end
      end else if (e_to) begin
        nrx = 0;
        quiet = 0;
      end else if (e_ready && nrx != 0) begin
        quiet++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, output int acc_cyc);
    bit got = 1'b0;
    int n = 0;
    acc_cyc = -1;
    bus.rx_tdata  = b;
    bus.rx_tvalid = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk);
      if (bus.rx_tready) begin
        got = 1'b1;
        acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
      n++;
    end
    bus.rx_tvalid = 1'b0;
    bus.rx_tdata  = '0;
    chk("rx_accept", 32'(got), 1);
  endtask

  // Stand-in ALU: waits for the start pulse, answers lat cycles later.
  task automatic alu_respond(input int lat, input logic [15:0] res);
    bit seen = 1'b0;
    int n = 0;
    while (!seen && n < 50) begin
      @(negedge clk);
      if (bus.alu_start) seen = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    chk("alu_start_seen", 32'(seen), 1);
    repeat (lat - 1) @(posedge clk);
    #1;
    bus.alu_done   = 1'b1;
    bus.alu_result = res;
    @(posedge clk);
    #1;
    bus.alu_done   = 1'b0;
    bus.alu_result = '0;
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    int n = 0;
    while (!idle && n < 200) begin
      @(negedge clk);
      if (!bus.busy) idle = 1'b1;
      n++;
    end
    chk("return_idle", 32'(idle), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string name, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2);
    logic [7:0] exp[3];
    exp[0] = b0; exp[1] = b1; exp[2] = b2;
    chk({name, "_count"}, 32'(tx_log.size()), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < tx_log.size()) chk({name, "_byte"}, 32'(tx_log[i]), 32'(exp[i]));
    end
    tx_log.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int ca, cb, c0, s0, tcyc, n;
    bit seen;
    bus.rx_tdata   = '0;
    bus.rx_tvalid  = 1'b0;
    bus.tx_tready  = 1'b1;
    bus.alu_done   = 1'b0;
    bus.alu_result = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rx_tready", 32'(bus.rx_tready), 1);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_tx_tvalid", 32'(bus.tx_tvalid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Valid op 02 05 03, ALU answers 0x0008 after 4 cycles.
    tx_log.delete();
    s0 = starts;
    send_byte(8'h02, ca);
    send_byte(8'h05, ca);
    send_byte(8'h03, cb);
    alu_respond(4, 16'h0008);
    chk("start_after_b", 32'(start_cyc - cb), 1);
    chk("valid_op", 32'(bus.alu_op), 32'h02);
    chk("valid_a", 32'(bus.alu_a), 32'h05);
    chk("valid_b", 32'(bus.alu_b), 32'h03);
    wait_idle();
    check_log("valid_tx", 8'h00, 8'h00, 8'h08);
    chk("valid_starts", 32'(starts - s0), 1);

    // Invalid op 0F 11 22.
    s0 = starts;
    send_byte(8'h0F, ca);
    send_byte(8'h11, ca);
    send_byte(8'h22, ca);
    wait_idle();
    check_log("invalid_tx", 8'h01, 8'h00, 8'h00);
    chk("invalid_starts", 32'(starts - s0), 0);
    chk("invalid_op_held", 32'(bus.alu_op), 32'h0F);

    // Backpressure: 10 stall cycles before each response byte.
    bus.tx_tready = 1'b0;
    send_byte(8'h04, ca);
    send_byte(8'h0A, ca);
    send_byte(8'h0B, ca);
    alu_respond(2, 16'h0015);
    for (int i = 0; i < 3; i++) begin
      repeat (10) @(posedge clk);
      #1;
      bus.tx_tready = 1'b1;
      @(posedge clk);
      #1;
      bus.tx_tready = 1'b0;
    end
    bus.tx_tready = 1'b1;
    wait_idle();
    check_log("bp_tx", 8'h00, 8'h00, 8'h15);

    // Timeout after opcode 01 and silence.
    send_byte(8'h01, ca);
    seen = 1'b0;
    n = 0;
    tcyc = -1;
    while (!seen && n < 40) begin
      @(negedge clk);
      if (bus.timeout) begin
        seen = 1'b1;
        tcyc = cyc;
      end
      n++;
    end
    chk("timeout_seen", 32'(seen), 1);
    chk("timeout_delay", 32'(tcyc - ca), 16);
    @(negedge clk);
    chk("timeout_busy_after", 32'(bus.busy), 0);
    chk("timeout_no_tx", 32'(tx_log.size()), 0);
    @(posedge clk);
    #1;
    send_byte(8'h01, ca);
    send_byte(8'h01, ca);
    send_byte(8'h01, ca);
    alu_respond(1, 16'h0002);
    wait_idle();
    check_log("after_to_tx", 8'h00, 8'h00, 8'h02);

    // Boundary: A accepted on the last allowed gap cycle.
    s0 = starts;
    send_byte(8'h05, c0);
    repeat (15) @(posedge clk);
    #1;
    send_byte(8'h30, ca);
    chk("boundary_gap", 32'(ca - c0), 16);
    send_byte(8'h40, cb);
    alu_respond(3, 16'h0070);
    wait_idle();
    check_log("boundary_tx", 8'h00, 8'h00, 8'h70);
    chk("boundary_starts", 32'(starts - s0), 1);

    // Reset during SEND_HI, then a stray ALU done.
    bus.tx_tready = 1'b0;
    send_byte(8'h06, ca);
    send_byte(8'h80, ca);
    send_byte(8'h90, ca);
    alu_respond(2, 16'h0110);
    bus.tx_tready = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_tready = 1'b0;
    @(negedge clk);
    chk("sendhi_tvalid", 32'(bus.tx_tvalid), 1);
    chk("sendhi_tdata", 32'(bus.tx_tdata), 32'h01);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_tvalid", 32'(bus.tx_tvalid), 0);
    chk("rst_tdata", 32'(bus.tx_tdata), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_op", 32'(bus.alu_op), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.tx_tready  = 1'b1;
    bus.alu_done   = 1'b1;
    bus.alu_result = 16'hBEEF;
    @(posedge clk);
    #1;
    bus.alu_done   = 1'b0;
    bus.alu_result = '0;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_tx_count", 32'(tx_log.size()), 1);
    if (tx_log.size() > 0) chk("rst_tx_stat", 32'(tx_log[0]), 32'h00);
    chk("rst_stray_busy", 32'(bus.busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
